// File: rtl/fir_sched_pkg.sv
// Shared types for the FIR MAC scheduler.
// Holds the FSM state encoding and channel-id type.
package fir_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  typedef logic ch_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter (combinational).
// Ports: pending[1:0], rr_last in; winner, valid out.
module rr_arbiter_2
  import fir_sched_pkg::*;
(
  input  logic [1:0] pending,
  input  ch_t        rr_last,
  output ch_t        winner,
  output logic       valid
);

  always_comb begin
    valid  = |pending;
    winner = 1'b0;
    unique case (1'b1)
      (pending == 2'b11): winner = ~rr_last;
      (pending == 2'b10): winner = 1'b1;
      default:            winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/fir_mac_sched.sv
// Shares one decimating FIR MAC between two channels.
// Ports: clk, reset, req, base0/1 in; busy, grant_ch,
// tap_idx, rd_addr, rd_en, acc_clr, acc_en, result_valid,
// result_ch, overrun out. All outputs registered.
module fir_mac_sched
  import fir_sched_pkg::*;
#(
  parameter int NUM_TAPS   = 183,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req,
  input  logic [ADDR_WIDTH-1:0] base0,
  input  logic [ADDR_WIDTH-1:0] base1,
  output logic                  busy,
  output ch_t                   grant_ch,
  output logic [ADDR_WIDTH-1:0] tap_idx,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_en,
  output logic                  acc_clr,
  output logic                  acc_en,
  output logic                  result_valid,
  output ch_t                   result_ch,
  output logic [1:0]            overrun
);

  localparam int AW1 = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_TAP =
    ADDR_WIDTH'(NUM_TAPS - 1);
  localparam logic [AW1-1:0] TAPS_W = AW1'(NUM_TAPS);
  localparam logic [2:0] DRAIN_LAST =
    3'(RD_LATENCY - 1);

  state_t state_q, state_d;

  logic [1:0] pending_q, pending_d;
  logic [1:0] clr;
  logic [1:0] overrun_d;
  logic [ADDR_WIDTH-1:0] sbase0_q, sbase1_q;

  logic [ADDR_WIDTH-1:0] job_base_q, job_base_d;
  logic [ADDR_WIDTH-1:0] arb_base;
  ch_t rr_last_q, rr_last_d;
  ch_t grant_ch_d;
  ch_t arb_win;
  logic arb_valid;

  logic [ADDR_WIDTH-1:0] tap_d, rd_addr_d;
  logic [ADDR_WIDTH-1:0] nxt_tap;
  logic [AW1-1:0] sum;
  logic rd_en_d, acc_clr_d;
  logic busy_d, rv_d;
  ch_t rch_d;
  logic [2:0] drain_q, drain_d;

  logic [RD_LATENCY-1:0] acc_sr;

  rr_arbiter_2 u_arb (
    .pending (pending_q),
    .rr_last (rr_last_q),
    .winner  (arb_win),
    .valid   (arb_valid)
  );

  assign arb_base = arb_win ? sbase1_q : sbase0_q;

  // A grant in this cycle clears the winner's pending
  // bit, but a same-cycle request re-arms it.
  always_comb begin
    clr = '0;
    if (state_q == IDLE && arb_valid)
      clr[arb_win] = 1'b1;
    pending_d = req | (pending_q & ~clr);
    overrun_d = req & pending_q & ~clr;
  end

  always_comb begin
    state_d    = state_q;
    job_base_d = job_base_q;
    grant_ch_d = grant_ch;
    rr_last_d  = rr_last_q;
    tap_d      = tap_idx;
    rd_addr_d  = rd_addr;
    rd_en_d    = 1'b0;
    acc_clr_d  = 1'b0;
    drain_d    = drain_q;
    nxt_tap    = tap_idx + ADDR_WIDTH'(1);
    sum        = {1'b0, job_base_q} + {1'b0, nxt_tap};
    if (sum >= TAPS_W)
      sum = sum - TAPS_W;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d    = ISSUE;
          grant_ch_d = arb_win;
          job_base_d = arb_base;
          tap_d      = '0;
          rd_addr_d  = arb_base;
          rd_en_d    = 1'b1;
          acc_clr_d  = 1'b1;
        end
      end
      ISSUE: begin
        if (tap_idx == LAST_TAP) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          tap_d     = nxt_tap;
          rd_addr_d = sum[ADDR_WIDTH-1:0];
          rd_en_d   = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST)
          state_d = DONE;
        else
          drain_d = drain_q + 3'd1;
      end
      DONE: begin
        state_d   = IDLE;
        rr_last_d = grant_ch;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    rv_d   = (state_d == DONE);
    rch_d  = rv_d ? grant_ch_d : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      sbase0_q     <= '0;
      sbase1_q     <= '0;
      job_base_q   <= '0;
      rr_last_q    <= 1'b1;
      drain_q      <= '0;
      busy         <= 1'b0;
      grant_ch     <= 1'b0;
      tap_idx      <= '0;
      rd_addr      <= '0;
      rd_en        <= 1'b0;
      acc_clr      <= 1'b0;
      result_valid <= 1'b0;
      result_ch    <= 1'b0;
      overrun      <= '0;
      acc_sr       <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      if (req[0])
        sbase0_q   <= base0;
      if (req[1])
        sbase1_q   <= base1;
      job_base_q   <= job_base_d;
      rr_last_q    <= rr_last_d;
      drain_q      <= drain_d;
      busy         <= busy_d;
      grant_ch     <= grant_ch_d;
      tap_idx      <= tap_d;
      rd_addr      <= rd_addr_d;
      rd_en        <= rd_en_d;
      acc_clr      <= acc_clr_d;
      result_valid <= rv_d;
      result_ch    <= rch_d;
      overrun      <= overrun_d;
      acc_sr[0]    <= rd_en;
      for (int i = 1; i < RD_LATENCY; i++)
        acc_sr[i]  <= acc_sr[i-1];
    end
  end

  assign acc_en = acc_sr[RD_LATENCY-1];

endmodule
